// File: rtl/load_store_bus_adapter.sv
// Load/store bus adapter: turns one load/store unit request into one or two
// word-aligned bus accesses with byte lanes, then returns extended load data
// with a single-cycle done pulse.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When defined, misaligned
// accesses are served (split across two words when needed). When undefined,
// misaligned accesses fault without touching the bus.

package load_store_bus_adapter_pkg;
    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } LoadStoreUnitCommand;

    typedef enum logic [2:0] {
        LST_BYTE          = 3'd0,
        LST_HALFWORD      = 3'd1,
        LST_WORD          = 3'd2,
        LST_UBYTE         = 3'd3,
        LST_UHALFWORD     = 3'd4
    } LoadStoreType;
endpackage

module load_store_bus_adapter
    import load_store_bus_adapter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  LoadStoreUnitCommand command,
    input  LoadStoreType        loadStoreType,
    input  logic [31:0]         addr,
    input  logic [31:0]         storeRegValue,
    output logic                done,
    output logic                fault,
    output logic [31:0]         result,
    output logic                memReq,
    output logic                memWrite,
    output logic [31:0]         memAddr,
    output logic [3:0]          memByteEnable,
    output logic [31:0]         memWriteValue,
    input  logic                memAck,
    input  logic                memError,
    input  logic [31:0]         memReadValue
);

    typedef enum logic [1:0] {IDLE, ACCESS0, ACCESS1, DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, store_q, lo_q, result_q;
    LoadStoreUnitCommand cmd_q;
    LoadStoreType        type_q;
    logic                fault_q;

    logic        is_mem_cmd, reject_in, split;
    logic        in_acc0, in_acc1, in_access, write_access;
    logic [3:0]  lane_mask, be_lo, be_hi;
    logic [2:0]  hi_shift;
    logic [5:0]  bit_shift;
    logic [31:0] word_addr, wdata_lo, wdata_hi, rd_lo, rd_hi, merged, load_value;

    function automatic logic [31:0] extend(input LoadStoreType t, input logic [31:0] d);
        case (t)
            LST_BYTE:      extend = {{24{d[7]}}, d[7:0]};
            LST_HALFWORD:  extend = {{16{d[15]}}, d[15:0]};
            LST_UBYTE:     extend = {24'b0, d[7:0]};
            LST_UHALFWORD: extend = {16'b0, d[15:0]};
            default:       extend = d;
        endcase
    endfunction

    assign is_mem_cmd = (command == CMD_LOAD) || (command == CMD_STORE);

`ifdef LSU_MISALIGN_SPLIT_EN
    // A second access is needed whenever lanes spill past the top of the low word.
    assign split     = |be_hi;
    assign reject_in = 1'b0;
`else
    assign split     = 1'b0;
    assign reject_in = (((loadStoreType == LST_HALFWORD) || (loadStoreType == LST_UHALFWORD)) && addr[0])
                     || ((loadStoreType == LST_WORD) && (addr[1:0] != 2'b00));
`endif

    // Lane and data alignment, all derived from the latched request.
    always_comb begin
        case (type_q)
            LST_BYTE, LST_UBYTE:         lane_mask = 4'b0001;
            LST_HALFWORD, LST_UHALFWORD: lane_mask = 4'b0011;
            default:                     lane_mask = 4'b1111;
        endcase
    end

    assign bit_shift = {1'b0, addr_q[1:0], 3'b000};
    assign hi_shift  = 3'd4 - {1'b0, addr_q[1:0]};
    assign be_lo     = lane_mask << addr_q[1:0];
    assign be_hi     = lane_mask >> hi_shift;
    assign wdata_lo  = store_q << bit_shift;
    assign wdata_hi  = store_q >> (6'd32 - bit_shift);
    assign word_addr = {addr_q[31:2], 2'b00};

    // Read merge: in ACCESS1 the low word was captured during ACCESS0.
    assign rd_lo      = (state_q == ACCESS1) ? lo_q : memReadValue;
    assign rd_hi      = (state_q == ACCESS1) ? memReadValue : 32'd0;
    assign merged     = (rd_lo >> bit_shift) | (rd_hi << (6'd32 - bit_shift));
    assign load_value = (cmd_q == CMD_LOAD) ? extend(type_q, merged) : 32'd0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (is_mem_cmd && !reject_in) state_d = ACCESS0;
                    else                          state_d = DONE;
                end
            end
            ACCESS0: begin
                if (memAck) begin
                    if (!memError && split) state_d = ACCESS1;
                    else                    state_d = DONE;
                end
            end
            ACCESS1: begin
                if (memAck) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read-data capture and completion status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
            lo_q     <= 32'd0;
            result_q <= 32'd0;
            cmd_q    <= CMD_NOP;
            type_q   <= LST_BYTE;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        addr_q   <= addr;
                        store_q  <= storeRegValue;
                        cmd_q    <= command;
                        type_q   <= loadStoreType;
                        fault_q  <= is_mem_cmd && reject_in;
                        result_q <= 32'd0;
                    end
                end
                ACCESS0: begin
                    if (memAck) begin
                        lo_q <= memReadValue;
                        if (memError) begin
                            fault_q  <= 1'b1;
                            result_q <= 32'd0;
                        end else if (!split) begin
                            result_q <= load_value;
                        end
                    end
                end
                ACCESS1: begin
                    if (memAck) begin
                        if (memError) begin
                            fault_q  <= 1'b1;
                            result_q <= 32'd0;
                        end else begin
                            result_q <= load_value;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_acc0      = (state_q == ACCESS0);
    assign in_acc1      = (state_q == ACCESS1);
    assign in_access    = in_acc0 || in_acc1;
    assign write_access = in_access && (cmd_q == CMD_STORE);

    assign memReq        = in_access;
    assign memWrite      = write_access;
    assign memAddr       = in_acc0 ? word_addr : (in_acc1 ? word_addr + 32'd4 : 32'd0);
    assign memByteEnable = in_acc0 ? be_lo : (in_acc1 ? be_hi : 4'd0);
    assign memWriteValue = write_access ? (in_acc0 ? wdata_lo : wdata_hi) : 32'd0;

    assign done   = (state_q == DONE);
    assign fault  = done && fault_q;
    assign result = done ? result_q : 32'd0;

endmodule

// File: doc/load_store_bus_adapter.md
LOAD_STORE_BUS_ADAPTER -- requirements
Module: load_store_bus_adapter

Interface
REQ-001 SHALL have the following ports (one clock; reset is asynchronous and active-high):
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  enable  in  1  request valid from load/store unit, held until done
  command  in  LoadStoreUnitCommand  Load, Store, or other (no-op)
  loadStoreType  in  LoadStoreType  Byte, HalfWord, Word, UnsignedByte, UnsignedHalfWord
  addr  in  32  byte address
  storeRegValue  in  32  store data, LSB-justified
  done  out  1  one-cycle completion pulse
  fault  out  1  valid with done; misaligned access or bus error
  result  out  32  load data, extended; valid with done
  memReq  out  1  bus request, held until memAck
  memWrite  out  1  1 = write
  memAddr  out  32  word-aligned address, bits [1:0] = 0
  memByteEnable  out  4  byte lanes
  memWriteValue  out  32  lane-aligned store data
  memAck  in  1  bus transfer complete
  memError  in  1  bus error, valid with memAck
  memReadValue  in  32  read data, valid with memAck

Function
REQ-002 SHALL implement FSM states IDLE, ACCESS0, ACCESS1, DONE.
REQ-003 IDLE: enable=1 and command Load/Store -> ACCESS0; enable=1 and any other command -> DONE, fault=0, result=0.
REQ-004 SHALL latch addr, command, loadStoreType and storeRegValue on leaving IDLE; later input changes SHALL be ignored until IDLE is re-entered.
REQ-005 ACCESS0/ACCESS1: memReq=1, with memAddr, memWrite, memByteEnable and memWriteValue stable until memAck.
REQ-006 memByteEnable and memWriteValue: byte = 0001 shifted by addr[1:0]; halfword = 0011 shifted; word = 1111; data shifted by 8*addr[1:0].
REQ-007 Loads: the selected lane SHALL be sign-extended for Byte/HalfWord and zero-extended for Unsigned*.
REQ-008 memAck with memError=0 in the final access -> DONE, with result registered.
REQ-009 memAck with memError=1 -> DONE, fault=1, result=0; no further access is issued.
REQ-010 DONE: done=1 for exactly one cycle, then -> IDLE; enable is ignored during DONE.
REQ-011 Minimum latency (single access, memAck in the first request cycle): enable sampled at edge N, done high in cycle N+2.
REQ-012 Outputs other than done/fault/result SHALL be 0 outside ACCESS states; done/fault/result SHALL be 0 outside DONE.
REQ-013 Misaligned = HalfWord/UnsignedHalfWord with addr[0]=1, or Word with addr[1:0]!=0; handled per REQ-016/017.

Reset
REQ-014 rst=1 SHALL force IDLE and all outputs to 0 asynchronously, including mid-access; an in-flight memAck is discarded.
REQ-015 The first request is accepted at the first rising edge after rst deasserts.

Configuration
REQ-016 Macro LSU_MISALIGN_SPLIT_EN defined:
  - a misaligned access within one word (halfword at offset 1) is served as a single access;
  - an access crossing a word boundary is split: ACCESS0 covers the low word's upper lanes, ACCESS1 covers memAddr+4's lower lanes;
  - load data is merged before extension;
  - an error in ACCESS0 skips ACCESS1.
REQ-017 Macro undefined: any misaligned access goes IDLE -> DONE with fault=1, issues no memReq, and ACCESS1 is unreachable.

Verification
REQ-018 Load Byte addr=0x1003, memReadValue=0x80AABBCC -> memByteEnable=1000, result=0xFFFFFF80, fault=0.
REQ-019 Store HalfWord addr=0x2002, storeRegValue=0x1234 -> memByteEnable=1100, memWriteValue[31:16]=0x1234, memWrite=1.
REQ-020 Load Word addr=0x3000, memAck held off 3 cycles -> memReq held 4 cycles, single done pulse with result=memReadValue.
REQ-021 Load UnsignedHalfWord addr=0x4000, memError=1 -> done=1, fault=1, result=0.
REQ-022 Load Word addr=0x5001: with macro -> two accesses at 0x5000 (1110) and 0x5004 (0001), merged result; without macro -> no memReq, fault=1 in cycle N+1.
REQ-023 rst asserted during ACCESS0 -> memReq=0 immediately, no done pulse, next request is served normally.
